// File: rtl/coin_input_conditioner_pkg.sv
// coin_pkg: shared widths, default credit values and types for the coin input conditioner.
package coin_pkg;
  localparam int NUM_CH = 3;
  localparam int AMT_W = 7;
  localparam int PEND_W = 2;
  localparam int VAL0_DEF = 5;
  localparam int VAL1_DEF = 10;
  localparam int VAL2_DEF = 20;
  typedef logic [AMT_W-1:0] credit_t;
  typedef logic [PEND_W-1:0] pend_t;
  localparam pend_t PEND_MAX = '1;
endpackage

// File: rtl/coin_input_conditioner_debounce.sv
// debounce_channel: 2-FF synchronizer, debouncer with init suppression, registered rising-edge pulse.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2, last, init, armed, level_d;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // Before init, wait for any steady sync level and adopt it silently, so a switch held through reset never credits.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      last <= 1'b0;
      init <= 1'b0;
      armed <= 1'b0;
      level <= 1'b0;
      level_d <= 1'b0;
      rise <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      last <= s2;
      level_d <= level;
      armed <= init;
      rise <= level & ~level_d & armed;
      if (!init) begin
        if (s2 != last) cnt <= '0;
        else if (done) begin
          level <= s2;
          init <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end else if (s2 == level) cnt <= '0;
      else if (done) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces coin switches, queues presses per channel, hands out credits by priority.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int VAL0 = VAL0_DEF,
  parameter int VAL1 = VAL1_DEF,
  parameter int VAL2 = VAL2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sw,
  input  logic              clear,
  input  logic              credit_ready,
  output logic              credit_valid,
  output credit_t           credit_amount,
  output logic [NUM_CH-1:0] sw_level,
  output logic              overflow
);
  localparam credit_t VALS [NUM_CH] = '{credit_t'(VAL0), credit_t'(VAL1), credit_t'(VAL2)};
  logic [NUM_CH-1:0] rise, pick, deq, drop;
  pend_t [NUM_CH-1:0] pend;
  credit_t amt;
  logic load;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(sw[i]),
      .level(sw_level[i]),
      .rise(rise[i])
    );
  end
  assign load = !credit_valid || credit_ready;
  assign deq = (load && !clear) ? pick : '0;
  // Lowest index wins: scan downwards so the last hit is the highest priority.
  always_comb begin
    pick = '0;
    amt = credit_amount;
    drop = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (pend[c] != '0) begin
        pick = '0;
        pick[c] = 1'b1;
        amt = VALS[c];
      end
    for (int c = 0; c < NUM_CH; c++)
      drop[c] = rise[c] && !deq[c] && !clear && pend[c] == PEND_MAX;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend <= '0;
      overflow <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (clear) pend[c] <= '0;
        else if (rise[c] && !deq[c] && pend[c] != PEND_MAX) pend[c] <= pend[c] + 1'b1;
        else if (deq[c] && !rise[c]) pend[c] <= pend[c] - 1'b1;
      if (|drop) overflow <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      credit_valid <= 1'b0;
      credit_amount <= '0;
    end else if (clear) credit_valid <= 1'b0;
    else if (load) begin
      credit_valid <= |pick;
      credit_amount <= amt;
    end
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed plan plus randomized rounds against a press-level credit scoreboard.
module tb_coin_input_conditioner;
  localparam int DEB = 8;
  logic clk = 1'b0, rst = 1'b0, clear = 1'b0, credit_ready = 1'b1;
  logic [2:0] sw = 3'b000;
  logic credit_valid, overflow;
  logic [6:0] credit_amount;
  logic [2:0] sw_level;
  int total = 0, bad = 0;
  int exp_q[$];
  int vals[3] = '{5, 10, 20};
  logic pv = 1'b0, pr = 1'b0, pc = 1'b0, prst = 1'b0;
  int pa = 0;

  always #5 clk = ~clk;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .clear(clear),
    .credit_ready(credit_ready),
    .credit_valid(credit_valid),
    .credit_amount(credit_amount),
    .sw_level(sw_level),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every transfer must match the next expected credit; stalled credits must not move.
  always @(negedge clk) begin
    if (rst && prst && pv && !pr && !pc) begin
      chk("hold_valid", credit_valid, 1);
      chk("hold_amount", credit_amount, pa);
    end
    if (rst && credit_valid && credit_ready) begin
      if (exp_q.size() == 0) chk("extra_credit", credit_amount, 0);
      else chk("credit_amount", credit_amount, exp_q.pop_front());
    end
    pv <= credit_valid;
    pa <= credit_amount;
    pr <= credit_ready;
    pc <= clear;
    prst <= rst;
  end

  initial begin
    int q_model, ovf_m;
    logic [2:0] m;
    #100_000_0;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int q_model;
    int ovf_m;
    logic [2:0] m;
    step(3);
    chk("rst_valid", credit_valid, 0);
    chk("rst_amount", credit_amount, 0);
    chk("rst_level", sw_level, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    step(20);

    exp_q.push_back(10);
    sw[1] = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk) chk("clean_early", credit_valid, 0);
    @(negedge clk) begin
      chk("clean_valid", credit_valid, 1);
      chk("clean_amount", credit_amount, 10);
    end
    @(negedge clk) chk("clean_once", credit_valid, 0);
    chk("clean_level", sw_level[1], 1);
    step();
    sw[1] = 1'b0;
    step(20);
    chk("clean_drained", exp_q.size(), 0);

    for (int i = 0; i < 10; i++) begin
      sw[0] = (i % 2 == 0);
      step(3);
    end
    chk("bounce_level", sw_level[0], 0);
    exp_q.push_back(5);
    sw[0] = 1'b1;
    step(20);
    chk("bounce_high", sw_level[0], 1);
    chk("bounce_drained", exp_q.size(), 0);
    sw[0] = 1'b0;
    step(20);
    chk("bounce_low", sw_level[0], 0);

    exp_q.push_back(5);
    exp_q.push_back(10);
    exp_q.push_back(20);
    sw = 3'b111;
    repeat (13) @(posedge clk);
    @(negedge clk) chk("simul_a", credit_valid ? int'(credit_amount) : 0, 5);
    @(negedge clk) chk("simul_b", credit_valid ? int'(credit_amount) : 0, 10);
    @(negedge clk) chk("simul_c", credit_valid ? int'(credit_amount) : 0, 20);
    @(negedge clk) chk("simul_end", credit_valid, 0);
    step();
    sw = 3'b000;
    step(20);
    chk("simul_drained", exp_q.size(), 0);

    credit_ready = 1'b0;
    q_model = 0;
    ovf_m = 0;
    for (int p = 1; p <= 5; p++) begin
      if (q_model < 4) begin
        q_model++;
        exp_q.push_back(20);
      end else ovf_m = 1;
      sw[2] = 1'b1;
      step(12);
      sw[2] = 1'b0;
      step(12);
      chk("sat_overflow", overflow, ovf_m);
    end
    chk("sat_valid", credit_valid, 1);
    chk("sat_amount", credit_amount, 20);
    credit_ready = 1'b1;
    step(10);
    chk("sat_drained", exp_q.size(), 0);
    chk("sat_sticky", overflow, 1);

    sw[0] = 1'b1;
    rst = 1'b0;
    step(2);
    chk("rst2_valid", credit_valid, 0);
    chk("rst2_overflow", overflow, 0);
    rst = 1'b1;
    step(20);
    chk("held_level", sw_level[0], 1);
    chk("held_none", credit_valid, 0);
    sw[0] = 1'b0;
    step(15);
    exp_q.push_back(5);
    sw[0] = 1'b1;
    step(15);
    chk("held_repress", exp_q.size(), 0);
    sw[0] = 1'b0;
    step(15);

    credit_ready = 1'b0;
    sw = 3'b011;
    step(15);
    chk("clr_pre_valid", credit_valid, 1);
    chk("clr_pre_amount", credit_amount, 5);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", credit_valid, 0);
    credit_ready = 1'b1;
    step(15);
    chk("clr_none", credit_valid, 0);
    chk("clr_overflow", overflow, 0);
    sw = 3'b000;
    step(15);

    for (int r = 0; r < 12; r++) begin
      m = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) if (m[i]) exp_q.push_back(vals[i]);
      for (int i = 0; i < 6; i++) begin
        sw = $urandom_range(0, 1) ? m : 3'b000;
        credit_ready = 1'($urandom_range(0, 1));
        step();
      end
      sw = m;
      for (int i = 0; i < 14; i++) begin
        credit_ready = 1'($urandom_range(0, 1));
        step();
      end
      chk("rnd_level_hi", sw_level, m);
      for (int i = 0; i < 6; i++) begin
        sw = $urandom_range(0, 1) ? m : 3'b000;
        credit_ready = 1'($urandom_range(0, 1));
        step();
      end
      sw = 3'b000;
      for (int i = 0; i < 14; i++) begin
        credit_ready = 1'($urandom_range(0, 1));
        step();
      end
      chk("rnd_level_lo", sw_level, 0);
      credit_ready = 1'b1;
      step(6);
      chk("rnd_drained", exp_q.size(), 0);
    end
    chk("rnd_overflow", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
